// File: rtl/dda_run_ctrl.sv
// Run controller for the DDA mass-spring-damper integrator: a register slave that shadows
// the initial conditions and coefficients, resets the DDA, then gates its clock enable for a set number of steps.
module dda_run_ctrl #(
   parameter int DATA_W     = 18,
   parameter int CNT_W      = 16,
   parameter int RST_CYCLES = 4
) (
   input  logic              clk0_020,
   input  logic              rst,
   input  logic [2:0]        address,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic              read,
   output logic [31:0]       readdata,
   output logic              irq,
   output logic              dda_rst,
   output logic              dda_clk_en,
   output logic [DATA_W-1:0] dda_ic_x,
   output logic [DATA_W-1:0] dda_ic_v,
   output logic [DATA_W-1:0] dda_B,
   output logic [DATA_W-1:0] dda_k,
   input  logic [8:0]        x_shift
);
   // state  | meaning
   // S_IDLE | DDA frozen, config registers writable
   // S_LOAD | dda_rst held high for RST_CYCLES cycles
   // S_RUN  | dda_clk_en high, one DDA step per cycle
   // S_DONE | single cycle, raises done
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int LW  = $clog2(RST_CYCLES + 1);
   localparam int PAD = 32 - DATA_W;

   state_t r_state, w_state_nxt;

   logic [DATA_W-1:0] r_ic_x, r_ic_v, r_b, r_k;
   logic [CNT_W-1:0]  r_steps, r_steps_done;
   logic [LW-1:0]     r_load_cnt;
   logic [8:0]        r_last_x;
   logic              r_irq_en, r_done, r_aborted, r_wr_err;
   logic              r_irq, r_dda_rst, r_dda_clk_en;
   logic [31:0]       r_readdata;
   logic [DATA_W-1:0] r_sh_x, r_sh_v, r_sh_b, r_sh_k;

   logic              w_wr_ctrl, w_start, w_abort, w_clr, w_busy;
   logic              w_wr_cfg, w_irq_en_nxt, w_done_nxt, w_run_end;
   logic [CNT_W-1:0]  w_step_nxt;
   logic [31:0]       w_rd_mux;

   assign w_busy       = (r_state == S_LOAD) || (r_state == S_RUN);
   assign w_wr_ctrl    = write && (address == 3'd0);
   assign w_start      = w_wr_ctrl && writedata[0] && !writedata[1] && (r_state == S_IDLE);
   assign w_abort      = w_wr_ctrl && writedata[1] && w_busy;
   assign w_clr        = w_wr_ctrl && writedata[2];
   assign w_wr_cfg     = write && (address >= 3'd2) && (address <= 3'd6);
   assign w_irq_en_nxt = w_wr_ctrl ? writedata[3] : r_irq_en;
   assign w_step_nxt   = r_steps_done + 1'b1;
   // STEPS=0 never matches, so the run continues until aborted
   assign w_run_end    = (r_steps != '0) && (w_step_nxt == r_steps);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_start) w_state_nxt = S_LOAD;
         S_LOAD: begin
            if (w_abort)                 w_state_nxt = S_IDLE;
            else if (r_load_cnt == '0)   w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_abort)                 w_state_nxt = S_IDLE;
            else if (w_run_end)          w_state_nxt = S_DONE;
         end
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // done-set takes priority over clr_flags
   always_comb begin
      w_done_nxt = r_done;
      if (r_state == S_DONE)     w_done_nxt = 1'b1;
      else if (w_start || w_clr) w_done_nxt = 1'b0;
   end

   always_comb begin
      w_rd_mux = '0;
      case (address)
         3'd0: w_rd_mux = {28'd0, r_irq_en, 3'd0};
         3'd1: w_rd_mux = {26'd0, r_state, r_wr_err, r_aborted, r_done, w_busy};
         3'd2: w_rd_mux = {{PAD{r_ic_x[DATA_W-1]}}, r_ic_x};
         3'd3: w_rd_mux = {{PAD{r_ic_v[DATA_W-1]}}, r_ic_v};
         3'd4: w_rd_mux = {{PAD{r_b[DATA_W-1]}}, r_b};
         3'd5: w_rd_mux = {{PAD{r_k[DATA_W-1]}}, r_k};
         3'd6: w_rd_mux = {{(32-CNT_W){1'b0}}, r_steps};
         3'd7: w_rd_mux = {r_steps_done, 7'd0, r_last_x};
         default: w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk0_020) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_ic_x       <= '0;
         r_ic_v       <= '0;
         r_b          <= '0;
         r_k          <= '0;
         r_steps      <= '0;
         r_steps_done <= '0;
         r_load_cnt   <= '0;
         r_last_x     <= '0;
         r_irq_en     <= 1'b0;
         r_done       <= 1'b0;
         r_aborted    <= 1'b0;
         r_wr_err     <= 1'b0;
         r_irq        <= 1'b0;
         r_dda_rst    <= 1'b1;
         r_dda_clk_en <= 1'b0;
         r_readdata   <= '0;
         r_sh_x       <= '0;
         r_sh_v       <= '0;
         r_sh_b       <= '0;
         r_sh_k       <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_dda_rst    <= (w_state_nxt == S_LOAD);
         r_dda_clk_en <= (w_state_nxt == S_RUN);
         r_irq_en     <= w_irq_en_nxt;
         r_done       <= w_done_nxt;
         r_irq        <= w_done_nxt && w_irq_en_nxt;

         if (w_start) begin
            r_sh_x       <= r_ic_x;
            r_sh_v       <= r_ic_v;
            r_sh_b       <= r_b;
            r_sh_k       <= r_k;
            r_steps_done <= '0;
            r_load_cnt   <= LW'(RST_CYCLES - 1);
         end else if ((r_state == S_LOAD) && (r_load_cnt != '0)) begin
            r_load_cnt <= r_load_cnt - 1'b1;
         end

         // every enabled cycle is a DDA step, including one cut short by abort
         if (r_state == S_RUN) begin
            r_steps_done <= w_step_nxt;
            r_last_x     <= x_shift;
         end

         if (w_abort)                 r_aborted <= 1'b1;
         else if (w_start || w_clr)   r_aborted <= 1'b0;

         if (w_wr_cfg && w_busy)      r_wr_err <= 1'b1;
         else if (w_clr)              r_wr_err <= 1'b0;

         if (w_wr_cfg && !w_busy) begin
            case (address)
               3'd2: r_ic_x  <= writedata[DATA_W-1:0];
               3'd3: r_ic_v  <= writedata[DATA_W-1:0];
               3'd4: r_b     <= writedata[DATA_W-1:0];
               3'd5: r_k     <= writedata[DATA_W-1:0];
               3'd6: r_steps <= writedata[CNT_W-1:0];
               default: ;
            endcase
         end

         if (read) r_readdata <= w_rd_mux;
      end
   end

   assign readdata   = r_readdata;
   assign irq        = r_irq;
   assign dda_rst    = r_dda_rst;
   assign dda_clk_en = r_dda_clk_en;
   assign dda_ic_x   = r_sh_x;
   assign dda_ic_v   = r_sh_v;
   assign dda_B      = r_sh_b;
   assign dda_k      = r_sh_k;
endmodule

// File: tb/tb_dda_run_ctrl.sv
// Directed bench for dda_run_ctrl: register access, run timing, abort, busy-write errors and mid-run reset.
module tb_dda_run_ctrl;
   logic        clk0_020 = 1'b0;
   logic        rst;
   logic [2:0]  address;
   logic        write;
   logic [31:0] writedata;
   logic        read;
   logic [31:0] readdata;
   logic        irq, dda_rst, dda_clk_en;
   logic [17:0] dda_ic_x, dda_ic_v, dda_B, dda_k;
   logic [8:0]  x_shift;

   int n_checks = 0;
   int n_fail   = 0;

   dda_run_ctrl dut (
      .clk0_020(clk0_020), .rst(rst), .address(address), .write(write),
      .writedata(writedata), .read(read), .readdata(readdata), .irq(irq),
      .dda_rst(dda_rst), .dda_clk_en(dda_clk_en), .dda_ic_x(dda_ic_x),
      .dda_ic_v(dda_ic_v), .dda_B(dda_B), .dda_k(dda_k), .x_shift(x_shift)
   );

   always #5 clk0_020 = ~clk0_020;

   // all bus tasks start and end on a falling edge
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; write = 1'b1;
      @(negedge clk0_020);
      write = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a; read = 1'b1;
      @(negedge clk0_020);
      read = 1'b0;
      d = readdata;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic test_reset;
      logic [31:0] d;
      rst = 1'b1;
      repeat (2) @(negedge clk0_020);
      n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL rst_readdata: got 0x%08h expected 0x0", readdata); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b expected 0", irq); end
      n_checks++; if (dda_clk_en !== 1'b0) begin n_fail++; $display("FAIL rst_clk_en: got %b expected 0", dda_clk_en); end
      n_checks++; if (dda_rst !== 1'b1) begin n_fail++; $display("FAIL rst_dda_rst: got %b expected 1", dda_rst); end
      rst = 1'b0;
      @(negedge clk0_020);
      n_checks++; if (dda_rst !== 1'b0) begin n_fail++; $display("FAIL rst_release_dda_rst: got %b expected 0", dda_rst); end
      rd(3'd1, d);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_status: got 0x%08h expected 0x0", d); end
   endtask

   task automatic test_run;
      logic [31:0] d;
      int n_rst = 0, n_en = 0;
      bit shadow_bad = 0;
      wr(3'd2, 32'h08000);
      wr(3'd3, 32'h0);
      wr(3'd5, 32'h10000);
      wr(3'd4, 32'h0);
      wr(3'd6, 32'd10);
      wr(3'd0, 32'h9);
      for (int i = 0; i < 30; i++) begin
         if (dda_rst) n_rst++;
         if (dda_clk_en) n_en++;
         if (dda_ic_x !== 18'h08000 || dda_k !== 18'h10000) shadow_bad = 1;
         @(negedge clk0_020);
      end
      n_checks++; if (n_rst != 4) begin n_fail++; $display("FAIL run_rst_cycles: got %0d expected 4", n_rst); end
      n_checks++; if (n_en != 10) begin n_fail++; $display("FAIL run_clk_en_cycles: got %0d expected 10", n_en); end
      n_checks++; if (shadow_bad) begin n_fail++; $display("FAIL run_shadow_stable: got unstable expected ic_x=0x08000 k=0x10000"); end
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL run_irq: got %b expected 1", irq); end
      rd(3'd1, d);
      n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL run_status: got 0x%08h expected 0x2", d); end
      rd(3'd7, d);
      n_checks++; if (d !== 32'h000A01A5) begin n_fail++; $display("FAIL run_result: got 0x%08h expected 0x000a01a5", d); end
   endtask

   task automatic test_sign;
      logic [31:0] d;
      wr(3'd4, 32'h3FFFF);
      rd(3'd4, d);
      chk("sign_b", d, 32'hFFFFFFFF);
      rd(3'd2, d);
      chk("ic_x_readback", d, 32'h00008000);
      rd(3'd0, d);
      chk("ctrl_readback", d, 32'h8);
   endtask

   task automatic test_abort;
      logic [31:0] d;
      int n_en = 0;
      wr(3'd6, 32'd0);
      wr(3'd0, 32'h9);
      for (int i = 0; i < 200 && n_en < 100; i++) begin
         if (dda_clk_en) n_en++;
         if (n_en < 100) @(negedge clk0_020);
      end
      chk("abort_reached_100", n_en, 100);
      wr(3'd0, 32'h2);
      chk("abort_clk_en", {31'd0, dda_clk_en}, 0);
      chk("abort_dda_rst", {31'd0, dda_rst}, 0);
      rd(3'd1, d);
      chk("abort_status", d, 32'h4);
      rd(3'd7, d);
      chk("abort_steps", {16'd0, d[31:16]}, 32'd100);
      chk("abort_irq", {31'd0, irq}, 0);
   endtask

   task automatic test_wr_err;
      logic [31:0] d;
      bit k_bad = 0;
      wr(3'd6, 32'd6);
      wr(3'd5, 32'h10000);
      wr(3'd0, 32'h9);
      wr(3'd5, 32'h00001);
      wr(3'd0, 32'h9);
      for (int i = 0; i < 20; i++) begin
         if (dda_k !== 18'h10000) k_bad = 1;
         @(negedge clk0_020);
      end
      chk("busy_k_shadow", {31'd0, k_bad}, 0);
      rd(3'd1, d);
      chk("busy_status", d, 32'hA);
      rd(3'd5, d);
      chk("busy_k_reg", d, 32'h00010000);
      rd(3'd7, d);
      chk("busy_steps", {16'd0, d[31:16]}, 32'd6);
      chk("busy_irq", {31'd0, irq}, 1);
      wr(3'd0, 32'h4);
      rd(3'd1, d);
      chk("clr_status", d, 32'h0);
      chk("clr_irq", {31'd0, irq}, 0);
   endtask

   task automatic test_idle_abort_and_rst;
      logic [31:0] d;
      int n_en = 0;
      wr(3'd0, 32'h3);
      chk("idle_abort_dda_rst", {31'd0, dda_rst}, 0);
      rd(3'd1, d);
      chk("idle_abort_status", d, 32'h0);
      wr(3'd6, 32'd20);
      wr(3'd0, 32'h1);
      for (int i = 0; i < 40 && n_en < 5; i++) begin
         if (dda_clk_en) n_en++;
         if (n_en < 5) @(negedge clk0_020);
      end
      chk("rst_mid_reached_5", n_en, 5);
      rst = 1'b1;
      @(negedge clk0_020);
      chk("rst_mid_clk_en", {31'd0, dda_clk_en}, 0);
      chk("rst_mid_dda_rst", {31'd0, dda_rst}, 1);
      rst = 1'b0;
      @(negedge clk0_020);
      rd(3'd1, d);
      chk("rst_mid_status", d, 32'h0);
      rd(3'd6, d);
      chk("rst_mid_steps_reg", d, 32'h0);
   endtask

   initial begin
      rst = 1'b1; address = '0; write = 1'b0; writedata = '0; read = 1'b0;
      x_shift = 9'h1A5;
      @(negedge clk0_020);
      test_reset;
      test_run;
      test_sign;
      test_abort;
      test_wr_err;
      test_idle_abort_and_rst;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
